// File: rtl/ebi_tx_serializer.sv
// rtl/ebi_tx_serializer.sv - off-die message serializer with inline parity, credit return and retransmit
module ebi_tx_serializer #(
    parameter int OFF_DIE_WD     = 4,
    parameter int MSG_W          = 64,
    parameter int BEAT_CNT_W     = 5,
    parameter int PARITY_LEN     = 8,
    parameter int CREDIT_W       = 2,
    parameter int CREDIT_TIMEOUT = 64,
    parameter int MAX_RETRY      = 3
) (
    input  logic                  bus_clk,
    input  logic                  rst,
    input  logic                  msg_valid,
    output logic                  msg_ready,
    input  logic [MSG_W-1:0]      msg_data,
    input  logic [BEAT_CNT_W-1:0] msg_beats,
    output logic [OFF_DIE_WD-1:0] bus_out,
    input  logic                  credit_in,
    output logic                  tx_done,
    output logic                  tx_error
);
    localparam int NB  = (MSG_W + OFF_DIE_WD - 1) / OFF_DIE_WD;
    localparam int PCW = $clog2(PARITY_LEN + 2);
    localparam int TW  = $clog2(CREDIT_TIMEOUT + 1);
    localparam int RW  = $clog2(MAX_RETRY + 2);
    localparam int DCW = $clog2(CREDIT_W + 1);
    localparam logic [OFF_DIE_WD-1:0] START_BEAT = {{(OFF_DIE_WD-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {IDLE, START, PAYLOAD, PARITY, WAIT_CREDIT} state_t;

    state_t                  r_state, w_state_nxt;
    logic [MSG_W-1:0]        r_hold;
    logic [BEAT_CNT_W-1:0]   r_beats;
    logic [BEAT_CNT_W-1:0]   r_idx, w_idx_nxt;
    logic [OFF_DIE_WD-1:0]   r_acc, w_acc_nxt, w_acc_upd;
    logic [PCW-1:0]          r_cnt, w_cnt_nxt, w_cnt_upd;
    logic [RW-1:0]           r_retry, w_retry_nxt;
    logic [TW-1:0]           r_timer, w_timer_nxt;
    logic [OFF_DIE_WD-1:0]   r_bus, w_bus_nxt, w_payload;
    logic                    r_done, w_done_nxt, r_err, w_err_nxt;
    logic                    w_load, w_fail, w_par_hit, w_last;
    logic [MSG_W+OFF_DIE_WD-1:0] w_ext;

    logic                    r_des_busy;
    logic [DCW-1:0]          r_des_cnt;
    logic [CREDIT_W-1:0]     r_des_shift;
    logic                    r_cred_valid;
    logic [CREDIT_W-1:0]     r_cred_val;

    assign msg_ready = (r_state == IDLE) && !rst;
    assign bus_out   = r_bus;
    assign tx_done   = r_done;
    assign tx_error  = r_err;

    // Padding with ones makes beats that run past MSG_W read back as idle bits.
    assign w_ext     = {{OFF_DIE_WD{1'b1}}, r_hold};
    assign w_acc_upd = r_acc ^ r_bus;
    assign w_cnt_upd = r_cnt + 1'b1;
    assign w_par_hit = (PARITY_LEN != 0) && (w_cnt_upd == PCW'(PARITY_LEN));
    assign w_last    = (r_idx == r_beats);

    always_comb begin
        w_payload = '1;
        for (int i = 0; i < NB; i++) begin
            if (r_idx == BEAT_CNT_W'(i)) w_payload = w_ext[i*OFF_DIE_WD +: OFF_DIE_WD];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bus_nxt   = '1;
        w_idx_nxt   = r_idx;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_timer_nxt = r_timer;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_load      = 1'b0;
        w_fail      = 1'b0;
        case (r_state)
            IDLE: begin
                if (msg_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = START;
                    w_bus_nxt   = START_BEAT;
                    w_idx_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                end
            end
            START, PAYLOAD: begin
                w_acc_nxt = w_acc_upd;
                w_cnt_nxt = w_cnt_upd;
                if (r_state == PAYLOAD && w_last) begin
                    w_state_nxt = WAIT_CREDIT;
                    w_timer_nxt = '0;
                end else if (w_par_hit) begin
                    w_state_nxt = PARITY;
                    w_bus_nxt   = w_acc_upd;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = PAYLOAD;
                    w_bus_nxt   = w_payload;
                    w_idx_nxt   = r_idx + 1'b1;
                end
            end
            PARITY: begin
                w_state_nxt = PAYLOAD;
                w_bus_nxt   = w_payload;
                w_idx_nxt   = r_idx + 1'b1;
            end
            WAIT_CREDIT: begin
                if (r_timer != TW'(CREDIT_TIMEOUT - 1)) w_timer_nxt = r_timer + 1'b1;
                // A credit frame in flight holds off the timeout until it resolves.
                if (r_cred_valid && r_cred_val == CREDIT_W'(1)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_cred_valid && r_cred_val != '0) begin
                    w_fail = 1'b1;
                end else if (r_timer == TW'(CREDIT_TIMEOUT - 1) && !r_des_busy && credit_in) begin
                    w_fail = 1'b1;
                end
                if (w_fail) begin
                    if (r_retry < RW'(MAX_RETRY)) begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_state_nxt = START;
                        w_bus_nxt   = START_BEAT;
                        w_idx_nxt   = '0;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_bus   <= '1;
            r_idx   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_retry <= '0;
            r_timer <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_hold  <= '0;
            r_beats <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bus   <= w_bus_nxt;
            r_idx   <= w_idx_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_retry <= w_retry_nxt;
            r_timer <= w_timer_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (w_load) begin
                r_hold  <= msg_data;
                r_beats <= msg_beats;
            end
        end
    end

    // Credit frame: one low start bit, then CREDIT_W data bits LSB first.
    always_ff @(posedge bus_clk) begin
        if (rst) begin
            r_des_busy   <= 1'b0;
            r_des_cnt    <= '0;
            r_des_shift  <= '0;
            r_cred_valid <= 1'b0;
            r_cred_val   <= '0;
        end else begin
            r_cred_valid <= 1'b0;
            if (!r_des_busy) begin
                if (!credit_in) begin
                    r_des_busy <= 1'b1;
                    r_des_cnt  <= '0;
                end
            end else begin
                r_des_shift <= {credit_in, r_des_shift[CREDIT_W-1:1]};
                if (r_des_cnt == DCW'(CREDIT_W - 1)) begin
                    r_des_busy   <= 1'b0;
                    r_cred_valid <= 1'b1;
                    r_cred_val   <= {credit_in, r_des_shift[CREDIT_W-1:1]};
                end else begin
                    r_des_cnt <= r_des_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/ebi_tx_serializer.md
EBI_TX_SERIALIZER -- requirements
Module: ebi_tx_serializer

Interface
REQ-001 SHALL have parameter OFF_DIE_WD, default 4: off-die bus width in bits.
REQ-002 SHALL have parameter MSG_W, default 64: max message width; channel ID occupies its low bits.
REQ-003 SHALL have parameter BEAT_CNT_W, default 5: width of the msg_beats field.
REQ-004 SHALL have parameter PARITY_LEN, default 8: beats covered by one parity beat; 0 disables parity.
REQ-005 SHALL have parameter CREDIT_W, default 2: credit value width.
REQ-006 SHALL have parameter CREDIT_TIMEOUT, default 64: bus_clk cycles to wait for a credit.
REQ-007 SHALL have parameter MAX_RETRY, default 3: retransmissions allowed per message.
REQ-008 SHALL have port bus_clk, input, 1: clock; all logic on posedge.
REQ-009 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-010 SHALL have port msg_valid, input, 1: message offered.
REQ-011 SHALL have port msg_ready, output, 1: message accepted when both valid and ready are high.
REQ-012 SHALL have port msg_data, input, MSG_W: message, channel ID in the LSBs.
REQ-013 SHALL have port msg_beats, input, BEAT_CNT_W: payload beat count, 1..ceil(MSG_W/OFF_DIE_WD).
REQ-014 SHALL have port bus_out, output, OFF_DIE_WD: registered serial bus to the peer receiver.
REQ-015 SHALL have port credit_in, input, 1: serial credit line from the peer; idles high.
REQ-016 SHALL have port tx_done, output, 1: one-cycle pulse when a message is acknowledged SUCCESS.
REQ-017 SHALL have port tx_error, output, 1: one-cycle pulse when a message is dropped after MAX_RETRY.

Function
REQ-018 SHALL drive bus_out all-ones while idle.
REQ-019 SHALL use a transmit FSM with states IDLE, START, PAYLOAD, PARITY, WAIT_CREDIT.
REQ-020 IDLE: msg_ready=1; on handshake SHALL capture msg_data/msg_beats into a hold buffer, clear the retry count, and go to START.
REQ-021 msg_ready SHALL be 0 in all states other than IDLE.
REQ-022 START: bus_out SHALL equal {all-ones, LSB 0} exactly one cycle after the handshake, then go to PAYLOAD.
REQ-023 PAYLOAD beat k (k=0..msg_beats-1) SHALL drive hold[k*OFF_DIE_WD +: OFF_DIE_WD]; bits beyond MSG_W SHALL be driven 1.
REQ-024 Parity accumulator SHALL XOR every start and payload beat and count them.
REQ-025 When the count reaches PARITY_LEN and payload beats remain, SHALL enter PARITY for one cycle, drive the accumulator, clear accumulator and count, then resume PAYLOAD.
REQ-026 SHALL NOT emit a parity beat after the final payload beat, even if the count equals PARITY_LEN there.
REQ-027 After the final payload beat SHALL go to WAIT_CREDIT with bus_out all-ones.
REQ-028 The credit deserializer SHALL detect a start bit (credit_in=0), then shift in CREDIT_W bits LSB-first, one per cycle.
REQ-029 Credit SUCCESS=1 (2'b01) SHALL pulse tx_done and return to IDLE.
REQ-030 Credit FAILURE=2 (2'b10), any other nonzero value, or a timeout SHALL count as a failure.
REQ-031 Timeout: CREDIT_TIMEOUT cycles in WAIT_CREDIT with no credit start bit detected.
REQ-032 On failure with retries < MAX_RETRY SHALL increment the retry count and retransmit from the hold buffer via START, with a bit-identical beat sequence.
REQ-033 On failure with retries == MAX_RETRY SHALL pulse tx_error and return to IDLE.
REQ-034 Credit value 0 (NO_CREDIT) SHALL be ignored: the deserializer re-arms and the timeout keeps running.
REQ-035 Credits arriving outside WAIT_CREDIT SHALL be deserialized and discarded.
REQ-036 Minimum gap between two messages SHALL be 1 idle beat, the IDLE handshake cycle.

Reset
REQ-037 rst SHALL force: FSM to IDLE, bus_out all-ones, msg_ready=0 in the reset cycle, tx_done=0, tx_error=0, all counters and the accumulator 0, credit deserializer idle.
REQ-038 rst asserted mid-message or mid-credit SHALL abort immediately, with no done/error pulse.
REQ-039 The first handshake SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-040 W=4, msg_beats=3, data=0xABC, PARITY_LEN=8 -> bus: E, C, B, A, then F; SUCCESS credit -> tx_done=1 for one cycle.
REQ-041 PARITY_LEN=2, beats=3, data=0x321 -> bus: E, 1, parity F, 2, 3, then F (idle); no parity after the final beat.
REQ-042 FAILURE credit, then SUCCESS credit -> identical beat sequence resent; exactly one tx_done; msg_ready=0 until done.
REQ-043 credit_in held high, CREDIT_TIMEOUT=16, MAX_RETRY=3 -> 4 transmissions, 16-cycle gaps, one tx_error, then msg_ready=1.
REQ-044 rst asserted during the PAYLOAD beat 1 -> next cycle bus_out=F, msg_ready=1 after release, no tx_done/tx_error.
REQ-045 NO_CREDIT then SUCCESS within the timeout -> single tx_done, no retransmission.
